// File: rtl/data_trans_fifo_mod_core_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_trans_fifo_mod_core_pkg : shared sizes, entry type and helpers
// Revision : 1.0
// -----------------------------------------------------------------------------
package data_trans_fifo_mod_core_pkg;

  localparam int DEPTH   = 16;
  localparam int SYM_W   = 5;
  localparam int ACC_W   = 12;
  localparam int ENTRY_W = 9;
  localparam int CNT_W   = 4;

  // A read is only started when a full byte still fits in the accumulator.
  localparam logic [CNT_W-1:0] RD_MAX_CNT = CNT_W'(ACC_W - 8);

  typedef struct packed {
    logic       is_byte;
    logic [7:0] data;
  } entry_t;

  function automatic logic [CNT_W-1:0] entry_bits(input logic is_byte);
    return is_byte ? CNT_W'(8) : CNT_W'(4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_trans_fifo_mod_core_byte_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// byte_fifo : synchronous FIFO with registered read data and registered flags
// Revision  : 1.0
// -----------------------------------------------------------------------------
module byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             w_wr;
  logic             w_rd;

  // Pointers wrap explicitly so non power-of-two depths also work.
  function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      rd_data <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (w_wr) begin
        r_wptr <= inc_ptr(r_wptr);
      end
      if (w_rd) begin
        r_rptr  <= inc_ptr(r_rptr);
        rd_data <= r_mem[r_rptr];
      end
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == CW'(DEPTH));
      empty   <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_trans_fifo_mod_core.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_trans_fifo_mod_core : byte/nibble FIFO feeding a 5-bit symbol packer
// Revision : 1.0
// -----------------------------------------------------------------------------
module data_trans_fifo_mod_core
  import data_trans_fifo_mod_core_pkg::*;
#(
  parameter int DEPTH = data_trans_fifo_mod_core_pkg::DEPTH,
  parameter int SYM_W = data_trans_fifo_mod_core_pkg::SYM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             start,
  input  logic             byte_flag,
  output logic [SYM_W-1:0] dmod,
  output logic             mod_en,
  output logic             full
);

  logic             empty;
  logic             rd_en;
  logic [7:0]       data_o_ino;

  entry_t           w_wr_entry;
  entry_t           w_rd_entry;
  logic             w_rd_is_byte;

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  logic             w_emit;
  logic [ACC_W-1:0] w_acc_post;
  logic [CNT_W-1:0] w_cnt_post;
  logic [ACC_W-1:0] w_new_bits;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_wr_entry.is_byte = byte_flag;
  assign w_wr_entry.data    = data_in;

  byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_byte_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (start),
    .wr_data (w_wr_entry),
    .rd_en   (rd_en),
    .rd_data (w_rd_entry),
    .full    (full),
    .empty   (empty)
  );

  assign data_o_ino   = w_rd_entry.data;
  assign w_rd_is_byte = w_rd_entry.is_byte;

  // Emit first, then append the entry read last cycle above the remaining bits.
  always_comb begin
    w_emit     = (r_cnt >= CNT_W'(SYM_W));
    w_acc_post = r_acc;
    w_cnt_post = r_cnt;
    if (w_emit) begin
      w_acc_post = r_acc >> SYM_W;
      w_cnt_post = r_cnt - CNT_W'(SYM_W);
    end

    w_new_bits = w_rd_is_byte ? ACC_W'(data_o_ino) : ACC_W'(data_o_ino[3:0]);
    w_acc_nxt  = w_acc_post;
    w_cnt_nxt  = w_cnt_post;
    if (r_pend) begin
      w_acc_nxt = w_acc_post | (w_new_bits << w_cnt_post);
      w_cnt_nxt = w_cnt_post + entry_bits(w_rd_is_byte);
    end
  end

  assign rd_en = !empty && !r_pend && (w_cnt_post <= RD_MAX_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_pend <= 1'b0;
      dmod   <= '0;
      mod_en <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_pend <= rd_en;
      mod_en <= w_emit;
      if (w_emit) begin
        dmod <= r_acc[SYM_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_trans_fifo_mod_core.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_trans_fifo_mod_core : directed vectors plus stream scoreboard
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_data_trans_fifo_mod_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       start = 1'b0;
  logic       byte_flag = 1'b0;
  logic [4:0] dmod;
  logic       mod_en;
  logic       full;

  data_trans_fifo_mod_core dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .start     (start),
    .byte_flag (byte_flag),
    .dmod      (dmod),
    .mod_en    (mod_en),
    .full      (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0][8:0] ent;
    logic [3:0]      n_sym;
    logic [7:0][4:0] sym;
  } vec_t;

  vec_t       vecs [3];
  int         checks = 0;
  int         errors = 0;
  bit         mon_on = 1'b0;
  int         m_cnt = 0;
  int         drops = 0;
  logic [8:0] acc_q [$];
  int         obs_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Records accepted writes and emitted symbols; tracks the expected FIFO fill.
  always @(negedge clk) begin
    if (mon_on) begin
      if (reset) begin
        m_cnt = 0;
        acc_q.delete();
        obs_q.delete();
      end else begin
        check("full_flag", full, m_cnt == 16);
        check("empty_flag", dut.empty, m_cnt == 0);
        if (mod_en) obs_q.push_back(int'(dmod));
        if (start && !full) begin
          acc_q.push_back({byte_flag, data_in});
          m_cnt++;
        end else if (start) begin
          drops++;
        end
        if (dut.rd_en) m_cnt--;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic write_entry(input logic flag, input logic [7:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    byte_flag = flag;
    data_in = d;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    byte_flag = 1'b0;
    data_in = 8'h00;
    @(posedge clk); #1;
    reset = 1'b0;
    check({tag, "_full"}, full, 0);
    check({tag, "_empty"}, dut.empty, 1);
    check({tag, "_mod_en"}, mod_en, 0);
    check({tag, "_dmod"}, dmod, 0);
    check({tag, "_rd_en"}, dut.rd_en, 0);
  endtask

  // Reference packer: LSB-first bit stream of accepted entries cut into 5-bit symbols.
  task automatic compare_stream(input string tag);
    int   exp_q [$];
    logic bq [$];
    int   n;
    int   s;
    foreach (acc_q[i]) begin
      n = acc_q[i][8] ? 8 : 4;
      for (int b = 0; b < n; b++) bq.push_back(acc_q[i][b]);
    end
    while (bq.size() >= 5) begin
      s = 0;
      for (int b = 0; b < 5; b++) s = s | (int'(bq.pop_front()) << b);
      exp_q.push_back(s);
    end
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_sym"}, obs_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_before;
    bit  saw_full;
    bit  got;

    vecs[0].ent   = {9'h19A, 9'h178, 9'h156, 9'h134, 9'h112};
    vecs[0].n_sym = 4'd8;
    vecs[0].sym   = {5'd19, 5'd9, 5'd28, 5'd5, 5'd12, 5'd13, 5'd0, 5'd18};
    vecs[1].ent   = {9'h0F5, 9'h0F4, 9'h0F3, 9'h0F2, 9'h0F1};
    vecs[1].n_sym = 4'd4;
    vecs[1].sym   = {5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 5'd16, 5'd25, 5'd1};
    vecs[2].ent   = {9'h1C3, 9'h076, 9'h10F, 9'h0B3, 9'h1A5};
    vecs[2].n_sym = 4'd6;
    vecs[2].sym   = {5'd0, 5'd0, 5'd1, 5'd22, 5'd1, 5'd28, 5'd29, 5'd5};

    mon_on = 1'b1;
    do_reset("rst");

    for (int r = 0; r < 3; r++) begin
      do_reset("row_rst");
      for (int k = 0; k < 5; k++) write_entry(vecs[r].ent[k][8], vecs[r].ent[k][7:0]);
      idle();
      cycles(40);
      check("row_sym_count", obs_q.size(), int'(vecs[r].n_sym));
      for (int j = 0; j < int'(vecs[r].n_sym) && j < obs_q.size(); j++)
        check("row_sym", obs_q[j], int'(vecs[r].sym[j]));
    end

    // Drain, idle, then resume: leftover bits must join the new data seamlessly.
    do_reset("cont_rst");
    for (int k = 0; k < 3; k++) write_entry(1'b1, 8'(8'hA0 + k * 13));
    idle();
    cycles(40);
    @(negedge clk);
    check("drained_empty", dut.empty, 1);
    n_before = obs_q.size();
    cycles(32);
    check("idle_no_sym", obs_q.size(), n_before);
    write_entry(1'b1, 8'h3C);
    write_entry(1'b1, 8'hC3);
    @(negedge clk);
    check("resume_empty_drop", dut.empty, 0);
    write_entry(1'b1, 8'h5A);
    write_entry(1'b0, 8'h96);
    write_entry(1'b1, 8'h0E);
    idle();
    cycles(60);
    compare_stream("resume");

    // Continuous writes outpace the packer until the FIFO fills.
    do_reset("full_rst");
    drops = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (full) begin
        saw_full = 1'b1;
        if (i >= 60) break;
      end
      start = 1'b1;
      byte_flag = 1'b1;
      data_in = 8'(i * 37 + 5);
    end
    start = 1'b0;
    check("full_seen", saw_full, 1);
    check("drops_seen", drops > 0, 1);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (dut.rd_en) got = 1'b1;
    end
    check("full_wait_read", got, 1);
    check("full_before_read", full, 1);
    @(negedge clk);
    check("full_after_read", full, 0);
    cycles(200);
    compare_stream("full_stream");

    // Reset in the middle of a stream discards everything before it.
    do_reset("pre_mid_rst");
    for (int k = 0; k < 5; k++) write_entry(1'b1, 8'(8'h11 * (k + 1)));
    idle();
    cycles(4);
    do_reset("mid_rst");
    for (int k = 0; k < 5; k++) write_entry(vecs[0].ent[k][8], vecs[0].ent[k][7:0]);
    idle();
    cycles(40);
    check("post_rst_count", obs_q.size(), 8);
    compare_stream("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
